// File: rtl/rv_data_mem.sv
// RV32 data memory: byte/half/word loads and stores, valid/ready requests, 1 or 2 cycle latency.
// Optional seven-segment readout of the last loaded byte: define RV_DATA_MEM_SEVSEG_EN.
module rv_data_mem #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
`ifdef RV_DATA_MEM_SEVSEG_EN
  ,
  output logic [6:0]        seg_hi,
  output logic [6:0]        seg_lo
`endif
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_clr_idx;
  logic               w_ready, w_busy;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= StReset;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= (r_state == StClear) ? r_clr_idx + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      StReset: w_state_next = (INIT_CLEAR != 0) ? StClear : StRun;
      StClear: begin
        w_busy = 1'b1;
        if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_next = StRun;
      end
      StRun:   w_ready = 1'b1;
      default: w_state_next = StReset;
    endcase
  end

  // Reset masks the handshake outputs combinationally so they read 0 on every reset edge.
  assign req_ready = w_ready & ~rst;
  assign init_busy = w_busy & ~rst;

  logic             w_accept, w_err;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  assign w_accept = req_valid & req_ready;
  assign w_lane   = req_addr[1:0];
  assign w_idx    = req_addr[ADDR_W-1:2];

  always_comb begin
    w_err = 1'b0;
    case (req_funct3)
      3'd0:    w_err = 1'b0;
      3'd1:    w_err = req_addr[0];
      3'd2:    w_err = |req_addr[1:0];
      3'd4:    w_err = req_we;
      3'd5:    w_err = req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << {w_lane[1], 1'b0};
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
    if (!(req_we && !w_err)) w_be = 4'b0000;
  end

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_rd_word;
  logic [3:0]       w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [31:0]      w_mem_wdata;

  always_comb begin
    w_mem_we    = w_accept ? w_be : 4'b0000;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_wdata;
    if (init_busy) begin
      w_mem_we    = 4'b1111;
      w_mem_idx   = r_clr_idx;
      w_mem_wdata = '0;
    end
  end

  // Single-port byte-enable RAM; a load one cycle after a store naturally sees the new word.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
    end
    if (w_accept && !req_we) r_rd_word <= r_mem[w_idx];
  end

  logic       r_s1_valid, r_s1_err, r_s1_load;
  logic [2:0] r_s1_f3;
  logic [1:0] r_s1_lane;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_load  <= 1'b0;
      r_s1_f3    <= 3'd0;
      r_s1_lane  <= 2'd0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_err  <= w_err;
        r_s1_load <= ~req_we & ~w_err;
        r_s1_f3   <= req_funct3;
        r_s1_lane <= w_lane;
      end
    end
  end

  logic [31:0] w_shift, w_rdata1;

  assign w_shift = r_rd_word >> {r_s1_lane, 3'b000};

  always_comb begin
    w_rdata1 = '0;
    case (r_s1_f3)
      3'd0:    w_rdata1 = {{24{w_shift[7]}}, w_shift[7:0]};
      3'd1:    w_rdata1 = {{16{w_shift[15]}}, w_shift[15:0]};
      3'd2:    w_rdata1 = r_rd_word;
      3'd4:    w_rdata1 = {24'd0, w_shift[7:0]};
      3'd5:    w_rdata1 = {16'd0, w_shift[15:0]};
      default: w_rdata1 = '0;
    endcase
  end

  logic        w_out_valid, w_out_err, w_out_load;
  logic [31:0] w_out_rdata;

  if (RD_LATENCY == 2) begin : g_out_reg
    logic        r_s2_valid, r_s2_err, r_s2_load;
    logic [31:0] r_s2_rdata;
    always_ff @(posedge clock) begin
      if (rst) begin
        r_s2_valid <= 1'b0;
        r_s2_err   <= 1'b0;
        r_s2_load  <= 1'b0;
        r_s2_rdata <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        r_s2_err   <= r_s1_err;
        r_s2_load  <= r_s1_load;
        r_s2_rdata <= w_rdata1;
      end
    end
    assign w_out_valid = r_s2_valid;
    assign w_out_err   = r_s2_err;
    assign w_out_load  = r_s2_load;
    assign w_out_rdata = r_s2_rdata;
  end else begin : g_out_comb
    assign w_out_valid = r_s1_valid;
    assign w_out_err   = r_s1_err;
    assign w_out_load  = r_s1_load;
    assign w_out_rdata = w_rdata1;
  end

  assign rsp_valid = w_out_valid & ~rst;
  assign rsp_err   = w_out_valid & w_out_err & ~rst;
  assign rsp_rdata = (w_out_valid & w_out_load & ~rst) ? w_out_rdata : '0;

`ifdef RV_DATA_MEM_SEVSEG_EN
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  logic [6:0] r_seg_hi, r_seg_lo;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_seg_hi <= 7'b1111110;
      r_seg_lo <= 7'b1111110;
    end else if (rsp_valid && !rsp_err && w_out_load) begin
      r_seg_hi <= hex_to_seg(rsp_rdata[7:4]);
      r_seg_lo <= hex_to_seg(rsp_rdata[3:0]);
    end
  end

  assign seg_hi = r_seg_hi;
  assign seg_lo = r_seg_lo;
`endif

endmodule
